// File: rtl/ram_access_ctrl_pkg.sv
// Shared definitions for the RAM load/store front end: access-size
// encodings, controller state encoding, default RAM address width and
// the alignment rule.
package ram_access_pkg;

  // Default RAM halfword address width (RAM span = 2^ADDR_W halfwords)
  localparam int unsigned ADDR_W_DEF = 10;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ACC0 = 3'd1,
    ST_ACC1 = 3'd2,
    ST_RMW  = 3'd3,
    ST_ERR  = 3'd4,
    ST_DONE = 3'd5
  } state_e;

  // Halfwords need an even byte address, words a 4-byte aligned one;
  // the reserved size is always rejected.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = |addr_lo;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/ram_access_ctrl_if.sv
// CPU-side request/response bus of the RAM access controller.
// The requester (CPU or bench) uses the master modport, the controller
// uses the slave modport.
interface ram_access_ctrl_if;

  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sgn;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        done;
  logic        err;
  logic [31:0] rdata;

  modport master (
    output req, we, size, sgn, addr, wdata,
    input  ready, done, err, rdata
  );

  modport slave (
    input  req, we, size, sgn, addr, wdata,
    output ready, done, err, rdata
  );

endinterface

// File: rtl/ram_access_ctrl_byte_lane_merge.sv
// Byte-lane datapath of the RAM access controller (purely combinational):
//  - load path: picks the addressed byte (or the whole halfword) out of a
//    captured RAM halfword and sign/zero extends it to 32 bits;
//  - store path: inserts the store byte into the addressed lane of the
//    halfword just read from RAM, for the read-modify-write.
import ram_access_pkg::*;

module byte_lane_merge (
  input  logic [15:0] i_load_hw,
  input  logic [15:0] i_rmw_hw,
  input  logic [7:0]  i_wbyte,
  input  logic        i_lane,
  input  logic        i_is_byte,
  input  logic        i_sgn,
  output logic [31:0] o_load_data,
  output logic [15:0] o_merged_hw
);

  logic [7:0] w_byte;

  // Load: lane select (little-endian, odd address = upper lane) and extension
  always_comb begin
    w_byte      = 8'h00;
    o_load_data = 32'h0000_0000;
    if (i_lane) begin
      w_byte = i_load_hw[15:8];
    end else begin
      w_byte = i_load_hw[7:0];
    end
    if (i_is_byte) begin
      o_load_data = {{24{i_sgn & w_byte[7]}}, w_byte};
    end else begin
      o_load_data = {{16{i_sgn & i_load_hw[15]}}, i_load_hw};
    end
  end

  // Store byte: replace the addressed lane of the read halfword
  always_comb begin
    o_merged_hw = 16'h0000;
    if (i_lane) begin
      o_merged_hw = {i_wbyte, i_rmw_hw[7:0]};
    end else begin
      o_merged_hw = {i_rmw_hw[15:8], i_wbyte};
    end
  end

endmodule

// File: rtl/ram_access_ctrl.sv
// Load/store front end for a 16-bit halfword RAM with asynchronous read.
// Turns byte/halfword/word requests on byte addresses into one or two RAM
// halfword cycles (byte stores via read-modify-write) and returns
// assembled, extended load data with a done pulse and an error flag.
import ram_access_pkg::*;

module ram_access_ctrl #(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  ram_access_ctrl_if.slave  bus,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [15:0]       o_ram_d,
  output logic              o_ram_we,
  input  logic [15:0]       i_ram_q
);

  state_e            r_state;
  state_e            w_next_state;

  // Request fields latched at accept; used for the whole access
  logic              r_we;
  logic [1:0]        r_size;
  logic              r_sgn;
  logic [ADDR_W:0]   r_addr;
  logic [31:0]       r_wdata;

  // Captured halves: low half also holds the merged RMW halfword
  logic [15:0]       r_lo;
  logic [15:0]       r_hi;

  logic              r_ready;
  logic              r_done;
  logic              r_err;
  logic [31:0]       r_rdata;

  logic              w_accept;
  logic              w_misaligned;
  logic [ADDR_W-1:0] w_hidx;
  logic [ADDR_W-1:0] w_hidx_hi;
  logic [31:0]       w_load_data;
  logic [15:0]       w_merged_hw;
  logic [31:0]       w_rdata_nxt;
  logic [ADDR_W-1:0] w_ram_addr;
  logic [15:0]       w_ram_d;
  logic              w_ram_we;

  assign w_accept     = (r_state == ST_IDLE) && r_ready && bus.req;
  assign w_misaligned = is_misaligned(bus.size, bus.addr[1:0]);
  assign w_hidx       = r_addr[ADDR_W:1];
  // Word halfword index is even, so the upper half never wraps
  assign w_hidx_hi    = {w_hidx[ADDR_W-1:1], 1'b1};

  byte_lane_merge u_lane (
    .i_load_hw   (r_lo),
    .i_rmw_hw    (i_ram_q),
    .i_wbyte     (r_wdata[7:0]),
    .i_lane      (r_addr[0]),
    .i_is_byte   (r_size == SZ_BYTE),
    .i_sgn       (r_sgn),
    .o_load_data (w_load_data),
    .o_merged_hw (w_merged_hw)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state sequencing of one access
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_misaligned) begin
            w_next_state = ST_ERR;
          end else begin
            w_next_state = ST_ACC0;
          end
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_ACC0: begin
        if (r_size == SZ_WORD) begin
          w_next_state = ST_ACC1;
        end else if (r_we && (r_size == SZ_BYTE)) begin
          w_next_state = ST_RMW;
        end else begin
          w_next_state = ST_DONE;
        end
      end
      ST_ACC1: w_next_state = ST_DONE;
      ST_RMW:  w_next_state = ST_DONE;
      ST_DONE: w_next_state = ST_IDLE;
      ST_ERR:  w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // RAM port decode from registered state and latched fields only
  always_comb begin
    w_ram_addr = {ADDR_W{1'b0}};
    w_ram_d    = 16'h0000;
    w_ram_we   = 1'b0;
    case (r_state)
      ST_ACC0: begin
        w_ram_addr = w_hidx;
        w_ram_d    = r_wdata[15:0];
        // A byte store only reads here; the write happens in RMW
        w_ram_we   = r_we && (r_size != SZ_BYTE);
      end
      ST_ACC1: begin
        w_ram_addr = w_hidx_hi;
        w_ram_d    = r_wdata[31:16];
        w_ram_we   = r_we;
      end
      ST_RMW: begin
        w_ram_addr = w_hidx;
        w_ram_d    = r_lo;
        w_ram_we   = 1'b1;
      end
      default: begin
        w_ram_addr = {ADDR_W{1'b0}};
        w_ram_d    = 16'h0000;
        w_ram_we   = 1'b0;
      end
    endcase
  end

  assign o_ram_addr = w_ram_addr;
  assign o_ram_d    = w_ram_d;
  assign o_ram_we   = w_ram_we;

  // Latch request fields at accept and capture RAM read data per access cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_size  <= 2'b00;
      r_sgn   <= 1'b0;
      r_addr  <= {(ADDR_W+1){1'b0}};
      r_wdata <= 32'h0000_0000;
      r_lo    <= 16'h0000;
      r_hi    <= 16'h0000;
    end else begin
      if (w_accept) begin
        r_we    <= bus.we;
        r_size  <= bus.size;
        r_sgn   <= bus.sgn;
        r_addr  <= bus.addr[ADDR_W:0];
        r_wdata <= bus.wdata;
      end
      case (r_state)
        ST_ACC0: begin
          if (r_we) begin
            r_lo <= w_merged_hw;
          end else begin
            r_lo <= i_ram_q;
          end
        end
        ST_ACC1: begin
          if (!r_we) begin
            r_hi <= i_ram_q;
          end
        end
        default: begin
          r_lo <= r_lo;
        end
      endcase
    end
  end

  // Final load value: word from both halves, otherwise lane-selected/extended
  always_comb begin
    w_rdata_nxt = 32'h0000_0000;
    if (r_size == SZ_WORD) begin
      w_rdata_nxt = {r_hi, r_lo};
    end else begin
      w_rdata_nxt = w_load_data;
    end
  end

  // Registered response: done/err pulse, load result, ready handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= 32'h0000_0000;
      r_ready <= 1'b1;
    end else begin
      r_done <= (r_state == ST_DONE) || (r_state == ST_ERR);
      r_err  <= (r_state == ST_ERR);
      if ((r_state == ST_DONE) && !r_we) begin
        r_rdata <= w_rdata_nxt;
      end
      // Busy from accept through the done cycle; free again the cycle after
      if (w_accept) begin
        r_ready <= 1'b0;
      end else if (r_done) begin
        r_ready <= 1'b1;
      end
    end
  end

  assign bus.ready = r_ready;
  assign bus.done  = r_done;
  assign bus.err   = r_err;
  assign bus.rdata = r_rdata;

endmodule
